// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// control-word field positions, MD encodings and FSM state encoding.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned MD_W    = 2;
    localparam int unsigned PFC_W   = 5;

    localparam int unsigned RS1_MSB = 34;
    localparam int unsigned RS1_LSB = 30;
    localparam int unsigned RS2_MSB = 29;
    localparam int unsigned RS2_LSB = 25;
    localparam int unsigned RD_MSB  = 24;
    localparam int unsigned RD_LSB  = 20;
    localparam int unsigned MD_MSB  = 17;
    localparam int unsigned MD_LSB  = 16;
    localparam int unsigned RW_BIT  = 15;
    localparam int unsigned FS_MSB  = 14;
    localparam int unsigned FS_LSB  = 9;
    localparam int unsigned MW_BIT  = 8;
    localparam int unsigned PFC_MSB = 4;
    localparam int unsigned PFC_LSB = 0;

    localparam logic [MD_W-1:0] MD_MEM = 2'd0;
    localparam logic [MD_W-1:0] MD_FU  = 2'd1;
    localparam logic [MD_W-1:0] MD_PC  = 2'd2;
    localparam logic [MD_W-1:0] MD_IMM = 2'd3;

    // Bit within FS that marks a multi-cycle functional-unit operation.
    localparam int unsigned FS_MC_BIT = 5;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational dependency check between ID and the EXE/MEM producers,
// flagging load-use and branch-operand hazards.
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CW_W = 35
) (
    input  logic [CW_W-1:0] ifid_cw_i,
    input  logic [CW_W-1:0] idexe_cw_i,
    input  logic [CW_W-1:0] exemem_cw_i,
    output logic            hazard_o
);

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] ex_rd;
    logic [REG_W-1:0] mem_rd;
    logic             id_branch;
    logic             ex_match;
    logic             mem_match;
    logic             ex_load;
    logic             mem_load;
    logic             unused_bits;

    assign id_rs1    = ifid_cw_i[RS1_MSB:RS1_LSB];
    assign id_rs2    = ifid_cw_i[RS2_MSB:RS2_LSB];
    assign ex_rd     = idexe_cw_i[RD_MSB:RD_LSB];
    assign mem_rd    = exemem_cw_i[RD_MSB:RD_LSB];
    assign id_branch = (ifid_cw_i[PFC_MSB:PFC_LSB] != '0);

    // x0 is hard-wired, so a write to it never creates a dependency.
    assign ex_match  = idexe_cw_i[RW_BIT] && (ex_rd != '0)
                       && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign mem_match = exemem_cw_i[RW_BIT] && (mem_rd != '0)
                       && ((mem_rd == id_rs1) || (mem_rd == id_rs2));

    assign ex_load   = idexe_cw_i[RW_BIT]  && (idexe_cw_i[MD_MSB:MD_LSB]  == MD_MEM);
    assign mem_load  = exemem_cw_i[RW_BIT] && (exemem_cw_i[MD_MSB:MD_LSB] == MD_MEM);

    // Branches resolve in ID, so they also wait on ALU results still in EXE.
    assign hazard_o  = (ex_match && ex_load)
                     || (id_branch && ex_match)
                     || (id_branch && mem_match && mem_load);

    assign unused_bits = ^{ifid_cw_i, idexe_cw_i, exemem_cw_i};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: hazard stalls, branch flush gating,
// multi-cycle FU start/done sequencing with timeout, performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CW_W       = 35,
    parameter int unsigned MC_TIMEOUT = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW_W-1:0]  ifid_cw,
    input  logic [CW_W-1:0]  idexe_cw,
    input  logic [CW_W-1:0]  exemem_cw,
    input  logic             pc_new_enable,
    input  logic             mc_done,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idexe_bubble,
    output logic             idexe_hold,
    output logic             exemem_bubble,
    output logic             ifid_flush,
    output logic             pc_load_en,
    output logic             mc_start,
    output logic             mc_busy,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

    state_e             state_q,     state_d;
    logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic               mc_err_q,    mc_err_d;
    logic               suppress_q,  suppress_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               hazard;
    logic               mc_op;

    hazard_detect #(
        .CW_W (CW_W)
    ) u_detect (
        .ifid_cw_i   (ifid_cw),
        .idexe_cw_i  (idexe_cw),
        .exemem_cw_i (exemem_cw),
        .hazard_o    (hazard)
    );

    assign mc_op = idexe_cw[FS_LSB + FS_MC_BIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mc_err_q    <= 1'b0;
            suppress_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mc_err_q    <= mc_err_d;
            suppress_q  <= suppress_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state and pipeline controls; multi-cycle sequencing outranks hazards.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mc_err_d      = mc_err_q;
        suppress_d    = 1'b0;
        pc_stall      = 1'b0;
        ifid_stall    = 1'b0;
        idexe_bubble  = 1'b0;
        idexe_hold    = 1'b0;
        exemem_bubble = 1'b0;
        mc_start      = 1'b0;
        mc_busy       = 1'b0;

        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (mc_op && !suppress_q) begin
                    mc_start      = 1'b1;
                    pc_stall      = 1'b1;
                    ifid_stall    = 1'b1;
                    idexe_hold    = 1'b1;
                    exemem_bubble = 1'b1;
                    state_d       = ST_MC_WAIT;
                end else if (hazard) begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idexe_bubble = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                mc_busy = 1'b1;
                // Release cycle drops the holds so the FU result latches into EXE/MEM.
                if (mc_done || (wait_cnt_q == WAIT_LAST)) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    suppress_d = 1'b1;
                    if (!mc_done) begin
                        mc_err_d = 1'b1;
                    end
                end else begin
                    pc_stall      = 1'b1;
                    ifid_stall    = 1'b1;
                    idexe_hold    = 1'b1;
                    exemem_bubble = 1'b1;
                    wait_cnt_d    = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        pc_load_en  = pc_new_enable && !pc_stall;
        ifid_flush  = pc_load_en;
        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush);
    end

    assign mc_err    = mc_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a behavioural model
// built from the pipeline rules (dependency checks, wait budget, counters).
module tb_hazard_ctrl;

    localparam int unsigned CW_W       = 35;
    localparam int unsigned MC_TIMEOUT = 16;
    localparam int unsigned CNT_W      = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [CW_W-1:0]  ifid_cw, idexe_cw, exemem_cw;
    logic             pc_new_enable, mc_done;
    logic             pc_stall, ifid_stall, idexe_bubble, idexe_hold, exemem_bubble;
    logic             ifid_flush, pc_load_en, mc_start, mc_busy, mc_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .CW_W       (CW_W),
        .MC_TIMEOUT (MC_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifid_cw       (ifid_cw),
        .idexe_cw      (idexe_cw),
        .exemem_cw     (exemem_cw),
        .pc_new_enable (pc_new_enable),
        .mc_done       (mc_done),
        .pc_stall      (pc_stall),
        .ifid_stall    (ifid_stall),
        .idexe_bubble  (idexe_bubble),
        .idexe_hold    (idexe_hold),
        .exemem_bubble (exemem_bubble),
        .ifid_flush    (ifid_flush),
        .pc_load_en    (pc_load_en),
        .mc_start      (mc_start),
        .mc_busy       (mc_busy),
        .mc_err        (mc_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    bit          m_wait;
    int          m_waited;
    bit          m_err;
    bit          m_skip;
    bit [31:0]   m_stall;
    bit [31:0]   m_flush;

    // Expected combinational outputs for the current cycle
    bit e_pc_stall, e_ifid_stall, e_idexe_bubble, e_idexe_hold, e_exemem_bubble;
    bit e_ifid_flush, e_pc_load_en, e_mc_start, e_mc_busy, e_release;

    logic [CW_W-1:0] nop_cw;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW_W-1:0] mk_cw(input int rs1, input int rs2, input int rd,
                                              input int md, input int rw, input int fs,
                                              input int pfc);
        logic [CW_W-1:0] c;
        c        = '0;
        c[34:30] = 5'(rs1);
        c[29:25] = 5'(rs2);
        c[24:20] = 5'(rd);
        c[17:16] = 2'(md);
        c[15]    = 1'(rw);
        c[14:9]  = 6'(fs);
        c[4:0]   = 5'(pfc);
        return c;
    endfunction

    function automatic logic [CW_W-1:0] rand_cw();
        logic [CW_W-1:0] c;
        int fs;
        int pfc;
        fs  = ($urandom_range(0, 11) == 0) ? 32 + int'($urandom_range(0, 31))
                                          : int'($urandom_range(0, 31));
        pfc = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 31));
        c = mk_cw(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1)), fs, pfc);
        c[19:18] = 2'($urandom);
        c[8]     = 1'($urandom);
        c[7:5]   = 3'($urandom);
        return c;
    endfunction

    // Producer x writes a live register that the ID instruction reads.
    function automatic bit depends(input logic [CW_W-1:0] x, input logic [CW_W-1:0] id);
        return x[15] && (x[24:20] != 0) && ((x[24:20] == id[34:30]) || (x[24:20] == id[29:25]));
    endfunction

    function automatic bit is_load(input logic [CW_W-1:0] x);
        return x[15] && (x[17:16] == 2'd0);
    endfunction

    task automatic model_reset();
        m_wait = 0; m_waited = 0; m_err = 0; m_skip = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit br;
        bit hz;
        bit hold_all;
        bit stall_only;
        br = (ifid_cw[4:0] != 0);
        hz = (depends(idexe_cw, ifid_cw) && is_load(idexe_cw))
           || (br && depends(idexe_cw, ifid_cw))
           || (br && depends(exemem_cw, ifid_cw) && is_load(exemem_cw));
        e_mc_start = 0; e_mc_busy = 0; e_release = 0;
        hold_all = 0; stall_only = 0;
        if (m_wait) begin
            e_mc_busy = 1;
            e_release = mc_done || (m_waited == int'(MC_TIMEOUT) - 1);
            hold_all  = !e_release;
        end else if (idexe_cw[14] && !m_skip) begin
            e_mc_start = 1;
            hold_all   = 1;
        end else begin
            stall_only = hz;
        end
        e_pc_stall      = hold_all || stall_only;
        e_ifid_stall    = hold_all || stall_only;
        e_idexe_bubble  = stall_only;
        e_idexe_hold    = hold_all;
        e_exemem_bubble = hold_all;
        e_pc_load_en    = pc_new_enable && !e_pc_stall;
        e_ifid_flush    = e_pc_load_en;
    endtask

    task automatic model_advance();
        if (m_wait) begin
            if (e_release) begin
                m_wait   = 0;
                m_skip   = 1;
                m_waited = 0;
                if (!mc_done) m_err = 1;
            end else begin
                m_waited++;
            end
        end else begin
            m_skip = 0;
            if (e_mc_start) begin
                m_wait   = 1;
                m_waited = 0;
            end
        end
        m_stall += 32'(e_pc_stall);
        m_flush += 32'(e_ifid_flush);
    endtask

    task automatic compare_all(input string tag);
        model_eval();
        check({tag, ":ctl"},
              {55'd0, pc_stall, ifid_stall, idexe_bubble, idexe_hold, exemem_bubble,
               ifid_flush, pc_load_en, mc_start, mc_busy},
              {55'd0, e_pc_stall, e_ifid_stall, e_idexe_bubble, e_idexe_hold, e_exemem_bubble,
               e_ifid_flush, e_pc_load_en, e_mc_start, e_mc_busy});
        check({tag, ":mc_err"},    64'(mc_err),    64'(m_err));
        check({tag, ":stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        check({tag, ":flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
    endtask

    task automatic step(input string tag, input logic [CW_W-1:0] id, input logic [CW_W-1:0] ex,
                        input logic [CW_W-1:0] mem, input logic pne, input logic done);
        @(negedge clk);
        ifid_cw = id; idexe_cw = ex; exemem_cw = mem; pc_new_enable = pne; mc_done = done;
        #1;
        compare_all(tag);
        @(posedge clk);
        model_advance();
    endtask

    initial begin
        logic [CW_W-1:0] ld5, add_rs5, add7, br_rs7, ld3, br_rs3, ld0, mcop;
        nop_cw = '0;
        ld5     = mk_cw(0, 0, 5, 0, 1, 0, 0);
        add_rs5 = mk_cw(5, 1, 9, 1, 1, 0, 0);
        add7    = mk_cw(1, 2, 7, 1, 1, 0, 0);
        br_rs7  = mk_cw(0, 7, 0, 2, 0, 0, 3);
        ld3     = mk_cw(0, 0, 3, 0, 1, 0, 0);
        br_rs3  = mk_cw(3, 0, 0, 2, 0, 0, 5);
        ld0     = mk_cw(0, 0, 0, 0, 1, 0, 0);
        mcop    = mk_cw(1, 2, 4, 1, 1, 6'b100000, 0);

        rst = 1'b0;
        ifid_cw = nop_cw; idexe_cw = nop_cw; exemem_cw = nop_cw;
        pc_new_enable = 1'b0; mc_done = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Load-use: one stall cycle
        step("ldu0", add_rs5, ld5, nop_cw, 0, 0);
        step("ldu1", nop_cw, add_rs5, ld5, 0, 0);
        // Branch after ALU: stall, then taken branch flushes
        step("bal0", br_rs7, add7, nop_cw, 1, 0);
        step("bal1", br_rs7, nop_cw, add7, 1, 0);
        // Branch after load: two stalls, then flush; rd=0 never stalls
        step("bld0", br_rs3, ld3, nop_cw, 1, 0);
        step("bld1", br_rs3, nop_cw, ld3, 1, 0);
        step("bld2", br_rs3, nop_cw, nop_cw, 1, 0);
        step("bz0",  br_rs3, ld0, nop_cw, 1, 0);
        step("bz1",  br_rs3, nop_cw, ld0, 1, 0);
        check("cnt_after_dir", 64'(stall_cnt), 64'd4);
        // Multi-cycle op with done three cycles after start; no restart afterwards
        step("mc0", nop_cw, mcop, nop_cw, 0, 0);
        step("mc1", nop_cw, mcop, nop_cw, 0, 0);
        step("mc2", nop_cw, mcop, nop_cw, 0, 0);
        step("mc3", nop_cw, mcop, nop_cw, 1, 1);
        step("mc4", nop_cw, mcop, nop_cw, 0, 0);
        check("mc_no_err", 64'(mc_err), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            step("rnd", rand_cw(), rand_cw(), rand_cw(), 1'($urandom),
                 ($urandom_range(0, 3) == 0));
        end

        // Timeout: mc_done never arrives
        step("to_flush", nop_cw, nop_cw, nop_cw, 0, 0);
        step("to_flush", nop_cw, nop_cw, nop_cw, 0, 0);
        for (int i = 0; i < int'(MC_TIMEOUT) + 3; i++) begin
            step("tmo", nop_cw, mcop, nop_cw, 0, 0);
        end
        step("tmo_end", nop_cw, nop_cw, nop_cw, 0, 0);
        check("mc_err_sticky", 64'(mc_err), 64'd1);

        // Reset asserted in the middle of a wait
        step("rmw0", nop_cw, mcop, nop_cw, 0, 0);
        step("rmw1", nop_cw, mcop, nop_cw, 0, 0);
        step("rmw2", nop_cw, mcop, nop_cw, 0, 0);
        @(negedge clk);
        idexe_cw = nop_cw;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_busy", 64'(mc_busy), 64'd0);
        check("rst_err", 64'(mc_err), 64'd0);
        check("rst_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
        compare_all("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", nop_cw, nop_cw, nop_cw, 0, 0);
        step("post_rst_ldu", add_rs5, ld5, nop_cw, 0, 0);

        for (int i = 0; i < 300; i++) begin
            step("rnd2", rand_cw(), rand_cw(), rand_cw(), 1'($urandom),
                 ($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
